// File: rtl/id_ex_issue.sv
// -----------------------------------------------------------------------------
// id_ex_issue
// Instruction-decode / issue stage of the MIPS pipeline. Decodes the ID-stage
// instruction into an ALU operation, operand pair and control bits, detects
// load-use hazards against the instruction currently in EX, and registers the
// result into the ID/EX pipeline register under a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   id_valid, id_instr    instruction offered by ID
//   id_rs_data/rt_data    forwarded register-file operands
//   id_ready              instruction consumed this cycle (combinational)
//   ex_stall, flush       hold / squash the ID/EX register
//   ex_*                  registered ID/EX contents feeding EX
// -----------------------------------------------------------------------------
module id_ex_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    output logic            id_ready,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [3:0]      ex_operation,
    output logic [4:0]      ex_shamt,
    output logic [4:0]      ex_dest,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_branch_eq,
    output logic            ex_branch_ne,
    output logic            ex_jr,
    output logic            ex_ovf_en,
    output logic            ex_illegal
);

    logic [5:0]      w_opcode, w_funct;
    logic [4:0]      w_rs, w_rt, w_rd;
    logic [XLEN-1:0] w_imm_sext, w_imm_zext;

    assign w_opcode   = id_instr[31:26];
    assign w_rs       = id_instr[25:21];
    assign w_rt       = id_instr[20:16];
    assign w_rd       = id_instr[15:11];
    assign w_funct    = id_instr[5:0];
    assign w_imm_sext = {{(XLEN-16){id_instr[15]}}, id_instr[15:0]};
    assign w_imm_zext = {{(XLEN-16){1'b0}}, id_instr[15:0]};

    logic [XLEN-1:0] w_op1, w_op2;
    logic [3:0]      w_operation;
    logic [4:0]      w_dest;
    logic            w_wr, w_mrd, w_mwr, w_beq, w_bne, w_jr, w_ovf, w_ill;
    logic            w_reads_rs, w_reads_rt;

    // Instruction decode: operation, operand selection, controls, source usage.
    always_comb begin
        w_op1       = id_rs_data;
        w_op2       = id_rt_data;
        w_operation = 4'h0;
        w_dest      = w_rt;
        w_wr        = 1'b0;
        w_mrd       = 1'b0;
        w_mwr       = 1'b0;
        w_beq       = 1'b0;
        w_bne       = 1'b0;
        w_jr        = 1'b0;
        w_ovf       = 1'b0;
        w_ill       = 1'b0;
        w_reads_rs  = 1'b1;
        w_reads_rt  = 1'b0;
        if (w_opcode == 6'h00) begin
            w_dest     = w_rd;
            w_reads_rt = 1'b1;
            w_wr       = 1'b1;
            case (w_funct)
                6'h20, 6'h21: begin w_operation = 4'h4; w_ovf = (w_funct == 6'h20); end
                // Subtract computes Op2-Op1, so operands are swapped to get rs-rt.
                6'h22, 6'h23: begin
                    w_operation = 4'h7;
                    w_op1       = id_rt_data;
                    w_op2       = id_rs_data;
                    w_ovf       = (w_funct == 6'h22);
                end
                6'h24: w_operation = 4'h5;
                6'h25: w_operation = 4'h3;
                6'h27: w_operation = 4'he;
                6'h2a: w_operation = 4'hc;
                6'h2b: w_operation = 4'hd;
                6'h00: begin w_operation = 4'h8; w_reads_rs = 1'b0; end
                6'h02: begin w_operation = 4'h9; w_reads_rs = 1'b0; end
                6'h08: begin
                    w_operation = 4'hf;
                    w_op2       = id_rs_data;
                    w_jr        = 1'b1;
                    w_wr        = 1'b0;
                end
                default: begin w_ill = 1'b1; w_wr = 1'b0; end
            endcase
        end else begin
            w_wr = 1'b1;
            case (w_opcode)
                6'h08, 6'h09: begin w_operation = 4'h4; w_op2 = w_imm_sext; w_ovf = (w_opcode == 6'h08); end
                6'h0c: begin w_operation = 4'h5; w_op2 = w_imm_zext; end
                6'h0d: begin w_operation = 4'h3; w_op2 = w_imm_zext; end
                6'h0a: begin w_operation = 4'hc; w_op2 = w_imm_sext; end
                6'h0b: begin w_operation = 4'hd; w_op2 = w_imm_sext; end
                6'h0f: begin w_operation = 4'hb; w_op2 = w_imm_zext; w_reads_rs = 1'b0; end
                6'h23: begin w_operation = 4'h4; w_op2 = w_imm_sext; w_mrd = 1'b1; end
                6'h2b: begin
                    w_operation = 4'h4;
                    w_op2       = w_imm_sext;
                    w_mwr       = 1'b1;
                    w_wr        = 1'b0;
                    w_reads_rt  = 1'b1;
                end
                6'h04, 6'h05: begin
                    w_operation = 4'h7;
                    w_op1       = id_rt_data;
                    w_op2       = id_rs_data;
                    w_beq       = (w_opcode == 6'h04);
                    w_bne       = (w_opcode == 6'h05);
                    w_wr        = 1'b0;
                    w_reads_rt  = 1'b1;
                end
                default: begin w_ill = 1'b1; w_wr = 1'b0; end
            endcase
        end
    end

    logic r_valid, r_wr, r_mrd, r_mwr, r_beq, r_bne, r_jr, r_ovf, r_ill;
    logic [XLEN-1:0] r_op1, r_op2, r_store;
    logic [3:0]      r_operation;
    logic [4:0]      r_shamt, r_dest;
    logic            w_haz;

    // Load-use: the load in EX targets a register this instruction reads.
    assign w_haz = r_valid & r_mrd & (r_dest != 5'd0) &
                   ((w_reads_rs & (w_rs == r_dest)) | (w_reads_rt & (w_rt == r_dest)));

    assign id_ready = id_valid & ~ex_stall & ~w_haz & ~flush;

    // ID/EX pipeline register: reset > flush > stall > hazard bubble > load > idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0; r_op1 <= '0; r_op2 <= '0; r_operation <= 4'h0;
            r_shamt <= 5'd0; r_dest <= 5'd0; r_store <= '0;
            r_wr <= 1'b0; r_mrd <= 1'b0; r_mwr <= 1'b0; r_beq <= 1'b0;
            r_bne <= 1'b0; r_jr <= 1'b0; r_ovf <= 1'b0; r_ill <= 1'b0;
        end else if (flush || (!ex_stall && !(id_valid && !w_haz))) begin
            // Squash, bubble or idle: drop validity and every control bit.
            r_valid <= 1'b0;
            r_wr <= 1'b0; r_mrd <= 1'b0; r_mwr <= 1'b0; r_beq <= 1'b0;
            r_bne <= 1'b0; r_jr <= 1'b0; r_ovf <= 1'b0; r_ill <= 1'b0;
        end else if (ex_stall) begin
            r_valid <= r_valid;
        end else begin
            r_valid     <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_operation <= w_operation;
            r_shamt     <= id_instr[10:6];
            r_dest      <= w_dest;
            r_store     <= id_rt_data;
            r_wr        <= w_wr & (w_dest != 5'd0);
            r_mrd       <= w_mrd;
            r_mwr       <= w_mwr;
            r_beq       <= w_beq;
            r_bne       <= w_bne;
            r_jr        <= w_jr;
            r_ovf       <= w_ovf;
            r_ill       <= w_ill;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_op1        = r_op1;
    assign ex_op2        = r_op2;
    assign ex_operation  = r_operation;
    assign ex_shamt      = r_shamt;
    assign ex_dest       = r_dest;
    assign ex_reg_write  = r_wr;
    assign ex_mem_read   = r_mrd;
    assign ex_mem_write  = r_mwr;
    assign ex_store_data = r_store;
    assign ex_branch_eq  = r_beq;
    assign ex_branch_ne  = r_bne;
    assign ex_jr         = r_jr;
    assign ex_ovf_en     = r_ovf;
    assign ex_illegal    = r_ill;

endmodule

// File: tb/tb_id_ex_issue.sv
module tb_id_ex_issue;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, ex_stall, flush;
    logic [31:0] id_instr, id_rs_data, id_rt_data;
    logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch_eq, ex_branch_ne, ex_jr, ex_ovf_en, ex_illegal;
    logic [31:0] ex_op1, ex_op2, ex_store_data;
    logic [3:0]  ex_operation;
    logic [4:0]  ex_shamt, ex_dest;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_issue #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_ready(id_ready),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_operation(ex_operation),
        .ex_shamt(ex_shamt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .ex_branch_eq(ex_branch_eq),
        .ex_branch_ne(ex_branch_ne), .ex_jr(ex_jr), .ex_ovf_en(ex_ovf_en),
        .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one cycle, then withdraw it.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        id_instr = ins; id_rs_data = rs; id_rt_data = rt; id_valid = 1'b1;
        step();
        id_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        id_instr = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0;
        step(); step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
        checks++; if (ex_operation !== 4'h0) begin errors++; $display("FAIL reset_op got=%0h exp=0", ex_operation); end
        checks++; if ({ex_op1, ex_op2, ex_store_data} !== 96'h0) begin errors++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", ex_op1, ex_op2, ex_store_data); end
        checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_eq, ex_branch_ne, ex_jr, ex_ovf_en, ex_illegal, ex_dest, ex_shamt} !== 18'h0) begin
            errors++; $display("FAIL reset_ctrl got nonzero controls exp=0"); end
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0h exp=0", id_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        id_instr = 32'h00221820; id_rs_data = 32'd5; id_rt_data = 32'd7; id_valid = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL add_ready got=%0h exp=1", id_ready); end
        step(); id_valid = 1'b0;
        checks++; if ({ex_valid, ex_operation, ex_dest} !== {1'b1, 4'h4, 5'd3}) begin
            errors++; $display("FAIL add_dec got v=%0h op=%0h d=%0d exp v=1 op=4 d=3", ex_valid, ex_operation, ex_dest); end
        checks++; if ({ex_op1, ex_op2} !== {32'd5, 32'd7}) begin
            errors++; $display("FAIL add_ops got=%0d,%0d exp=5,7", ex_op1, ex_op2); end
        checks++; if ({ex_reg_write, ex_ovf_en, ex_illegal} !== 3'b110) begin
            errors++; $display("FAIL add_ctrl got wr=%0h ovf=%0h ill=%0h exp 1,1,0", ex_reg_write, ex_ovf_en, ex_illegal); end
    endtask

    task automatic test_sub_lui();
        issue(32'h00221822, 32'd9, 32'd4);
        checks++; if ({ex_operation, ex_op1, ex_op2, ex_ovf_en} !== {4'h7, 32'd4, 32'd9, 1'b1}) begin
            errors++; $display("FAIL sub got op=%0h op1=%0d op2=%0d ovf=%0h exp 7,4,9,1", ex_operation, ex_op1, ex_op2, ex_ovf_en); end
        issue(32'h3C041234, 32'd0, 32'd0);
        checks++; if ({ex_operation, ex_op2, ex_dest, ex_reg_write, ex_ovf_en} !== {4'hb, 32'h00001234, 5'd4, 1'b1, 1'b0}) begin
            errors++; $display("FAIL lui got op=%0h op2=%0h d=%0d wr=%0h exp b,1234,4,1", ex_operation, ex_op2, ex_dest, ex_reg_write); end
    endtask

    task automatic test_imm_ext();
        issue(32'h2026FFFF, 32'd1, 32'd0);
        checks++; if ({ex_operation, ex_op2, ex_dest, ex_ovf_en} !== {4'h4, 32'hFFFFFFFF, 5'd6, 1'b1}) begin
            errors++; $display("FAIL addi_sext got op=%0h op2=%0h d=%0d ovf=%0h", ex_operation, ex_op2, ex_dest, ex_ovf_en); end
        issue(32'h3026FFFF, 32'd1, 32'd0);
        checks++; if ({ex_operation, ex_op2, ex_ovf_en} !== {4'h5, 32'h0000FFFF, 1'b0}) begin
            errors++; $display("FAIL andi_zext got op=%0h op2=%0h ovf=%0h", ex_operation, ex_op2, ex_ovf_en); end
    endtask

    task automatic test_sw_beq();
        issue(32'hAC250008, 32'd100, 32'h0000DEAD);
        checks++; if ({ex_operation, ex_op1, ex_op2, ex_mem_write, ex_reg_write, ex_store_data} !== {4'h4, 32'd100, 32'd8, 1'b1, 1'b0, 32'h0000DEAD}) begin
            errors++; $display("FAIL sw got op=%0h op1=%0d op2=%0d mw=%0h wr=%0h sd=%0h", ex_operation, ex_op1, ex_op2, ex_mem_write, ex_reg_write, ex_store_data); end
        issue(32'h10220004, 32'd3, 32'd8);
        checks++; if ({ex_operation, ex_op1, ex_op2, ex_branch_eq, ex_branch_ne, ex_reg_write} !== {4'h7, 32'd8, 32'd3, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL beq got op=%0h op1=%0d op2=%0d beq=%0h bne=%0h wr=%0h", ex_operation, ex_op1, ex_op2, ex_branch_eq, ex_branch_ne, ex_reg_write); end
    endtask

    task automatic test_load_use();
        issue(32'h8C220000, 32'd0, 32'd0);
        id_instr = 32'h00421820; id_rs_data = 32'd11; id_rt_data = 32'd11; id_valid = 1'b1;
        #1;
        checks++; if ({ex_valid, ex_mem_read, ex_dest} !== {1'b1, 1'b1, 5'd2}) begin
            errors++; $display("FAIL lw_in_ex got v=%0h mr=%0h d=%0d exp 1,1,2", ex_valid, ex_mem_read, ex_dest); end
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL haz_ready got=%0h exp=0", id_ready); end
        step();
        checks++; if ({ex_valid, id_ready} !== 2'b01) begin
            errors++; $display("FAIL haz_bubble got v=%0h rdy=%0h exp v=0 rdy=1", ex_valid, id_ready); end
        step(); id_valid = 1'b0;
        checks++; if ({ex_valid, ex_operation, ex_dest, ex_op1, ex_op2} !== {1'b1, 4'h4, 5'd3, 32'd11, 32'd11}) begin
            errors++; $display("FAIL haz_issue got v=%0h op=%0h d=%0d op1=%0d op2=%0d", ex_valid, ex_operation, ex_dest, ex_op1, ex_op2); end
    endtask

    task automatic test_stall_flush();
        issue(32'h00221820, 32'd5, 32'd7);
        ex_stall = 1'b1;
        id_instr = 32'h00221822; id_rs_data = 32'd9; id_rt_data = 32'd4; id_valid = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0h exp=0", id_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({ex_valid, ex_operation, ex_op1, ex_op2, ex_reg_write} !== {1'b1, 4'h4, 32'd5, 32'd7, 1'b1}) begin
                errors++; $display("FAIL stall_hold%0d got v=%0h op=%0h op1=%0d op2=%0d", i, ex_valid, ex_operation, ex_op1, ex_op2); end
        end
        flush = 1'b1;
        step();
        checks++; if ({ex_valid, ex_reg_write, ex_ovf_en} !== 3'b000) begin
            errors++; $display("FAIL stall_flush got v=%0h wr=%0h ovf=%0h exp 0", ex_valid, ex_reg_write, ex_ovf_en); end
        flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal_nop();
        issue(32'hFC000000, 32'd1, 32'd2);
        checks++; if ({ex_valid, ex_illegal, ex_operation, ex_reg_write, ex_mem_read, ex_mem_write} !== {1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL illegal got v=%0h ill=%0h op=%0h wr=%0h", ex_valid, ex_illegal, ex_operation, ex_reg_write); end
        issue(32'h00000000, 32'd0, 32'd0);
        checks++; if ({ex_valid, ex_operation, ex_reg_write, ex_illegal} !== {1'b1, 4'h8, 1'b0, 1'b0}) begin
            errors++; $display("FAIL nop got v=%0h op=%0h wr=%0h ill=%0h exp 1,8,0,0", ex_valid, ex_operation, ex_reg_write, ex_illegal); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL idle got=%0h exp=0", ex_valid); end
    endtask

    task automatic test_reset_mid_stall();
        issue(32'h00221820, 32'd5, 32'd7);
        ex_stall = 1'b1; rst_n = 1'b0;
        step();
        checks++; if ({ex_valid, ex_operation, ex_op1} !== {1'b0, 4'h0, 32'd0}) begin
            errors++; $display("FAIL rst_stall got v=%0h op=%0h op1=%0d exp 0", ex_valid, ex_operation, ex_op1); end
        rst_n = 1'b1; ex_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_lui();
        test_imm_ext();
        test_sw_beq();
        test_load_use();
        test_stall_flush();
        test_illegal_nop();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Instruction-decode/issue stage for the MIPS pipeline; feeds the EX-stage ALU.
- Decodes a 32-bit instruction into the ALU operation code, shamt and operand pair (Op1/Op2), plus control bits.
- Detects load-use hazards and registers everything into the ID/EX pipeline register under a valid/ready handshake with stall and flush.

Parameters:
- XLEN, 32, datapath width of operands and instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- id_valid  input  1  ID holds a valid instruction.
- id_instr  input  32  instruction word.
- id_rs_data  input  32  register-file value of rs, already forwarded.
- id_rt_data  input  32  register-file value of rt, already forwarded.
- id_ready  output  1  instruction is consumed this cycle (combinational).
- ex_stall  input  1  EX cannot accept; hold ID/EX register.
- flush  input  1  squash ID/EX contents (branch/jr redirect).
- ex_valid  output  1  ID/EX register holds a live instruction.
- ex_op1  output  32  ALU Op1.
- ex_op2  output  32  ALU Op2.
- ex_operation  output  4  ALU operation code.
- ex_shamt  output  5  shift amount, instr[10:6].
- ex_dest  output  5  destination register.
- ex_reg_write  output  1  writes ex_dest.
- ex_mem_read  output  1  load.
- ex_mem_write  output  1  store.
- ex_store_data  output  32  rt value for sw.
- ex_branch_eq  output  1  beq.
- ex_branch_ne  output  1  bne.
- ex_jr  output  1  jr.
- ex_ovf_en  output  1  Overflow from the ALU traps (add/sub/addi only).
- ex_illegal  output  1  undecodable instruction.

Behaviour:
- Reset (rst_n=0 at edge): all ex_* outputs 0, including ex_operation=4'h0.
- ALU codes: 3=OR, 4=ADD, 5=AND, 7=SUB (result=Op2-Op1), 8=SLL, 9=SRL, b=Op2<<16, c=SLT, d=SLTU, e=NOR, f=pass Op2.
- R-type (opcode 0), dest=rd, Op1=rs, Op2=rt unless noted:
  - funct 20/21 add/addu: 4.
  - 22/23 sub/subu: 7, with Op1=rt and Op2=rs.
  - 24 and: 5. 25 or: 3. 27 nor: e.
  - 2a slt: c. 2b sltu: d.
  - 00 sll: 8. 02 srl: 9; Op2=rt.
  - 08 jr: f, Op2=rs, no write.
- I-type, dest=rt, Op1=rs, Op2=imm:
  - 08/09 addi/addiu: 4, sign-extended imm.
  - 0c andi: 5, zero-extended. 0d ori: 3, zero-extended.
  - 0a slti: c, sign-extended. 0b sltiu: d, sign-extended.
  - 0f lui: b, Op2=zero-extended imm.
  - 23 lw: 4, sign-extended, mem_read.
  - 2b sw: 4, sign-extended, mem_write, no reg write.
  - 04 beq / 05 bne: 7, Op1=rt, Op2=rs, no write.
- ex_ovf_en=1 only for add, sub, addi.
- Any other opcode/funct: operation 4'h0, ex_illegal=1, all write/mem/branch bits 0, ex_valid still 1.
- ex_reg_write forced 0 when dest=0 (0x00000000 is a harmless sll bubble).
- Hazard: haz=1 when ex_valid & ex_mem_read & ex_dest!=0 and ex_dest matches an rs/rt the ID instruction actually reads.
  - Reads rs: everything except lui, sll, srl.
  - Reads rt: R-type, sw, beq, bne.
- id_ready = id_valid & ~ex_stall & ~haz & ~flush.
- Register update priority each edge:
  1. rst_n=0: clear.
  2. flush: ex_valid=0, control bits cleared.
  3. ex_stall: hold all ex_*.
  4. haz: bubble, ex_valid=0 with controls cleared.
  5. id_valid: load decoded instruction, ex_valid=1.
  6. Else: ex_valid=0.
- Latency: one cycle from id_ready=1 to the instruction on ex_*.
- flush together with ex_stall: flush wins.
- Reset mid-stall discards held instruction.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all ex_* 0, id_ready=0.
- add $3,$1,$2 (0x00221820), rs=5, rt=7 -> next cycle: operation=4, op1=5, op2=7, dest=3, reg_write=1, ovf_en=1.
- sub $3,$1,$2 with rs=9, rt=4 -> op1=4, op2=9, operation=7. lui $4,0x1234 -> operation=b, op2=0x00001234, dest=4.
- lw $2,0($1) then add $3,$2,$2 -> bubble inserted (ex_valid=0, id_ready=0 one cycle), add issues next cycle.
- ex_stall=1 and flush=1 in the same cycle while an instruction is held -> ex_valid=0 next cycle. ex_stall alone -> ex_* unchanged for 3 stalled cycles.
- opcode 0x3f -> ex_illegal=1, operation=0, reg_write=0. 0x00000000 -> operation=8, reg_write=0.
